// File: rtl/grf_wb_sink.sv
// General register file terminating the write-back interface: two bypassed read
// ports for decode plus a registered commit trace and a committed-write counter.
module grf_wb_sink #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD,
    input  logic [31:0]       PC4,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              trace_valid,
    output logic [31:0]       trace_pc,
    output logic [ADDR_W-1:0] trace_reg,
    output logic [DATA_W-1:0] trace_data,
    output logic [CNT_W-1:0]  commit_cnt
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    logic              trace_valid_q, trace_valid_d;
    logic [31:0]       trace_pc_q,    trace_pc_d;
    logic [ADDR_W-1:0] trace_reg_q,   trace_reg_d;
    logic [DATA_W-1:0] trace_data_q,  trace_data_d;
    logic [CNT_W-1:0]  commit_cnt_q,  commit_cnt_d;

    logic commit;

    // Writes to register 0 are dropped entirely: no storage, trace or count effect.
    assign commit = RegWrite && (A3 != '0);

    always_comb begin
        regs_d = regs_q;
        if (commit) begin
            regs_d[A3] = WD;
        end
    end

    always_comb begin
        trace_valid_d = commit;
        trace_pc_d    = trace_pc_q;
        trace_reg_d   = trace_reg_q;
        trace_data_d  = trace_data_q;
        commit_cnt_d  = commit_cnt_q;
        if (commit) begin
            trace_pc_d   = PC4;
            trace_reg_d  = A3;
            trace_data_d = WD;
            commit_cnt_d = commit_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            trace_valid_q <= 1'b0;
            trace_pc_q    <= '0;
            trace_reg_q   <= '0;
            trace_data_q  <= '0;
            commit_cnt_q  <= '0;
        end else begin
            regs_q        <= regs_d;
            trace_valid_q <= trace_valid_d;
            trace_pc_q    <= trace_pc_d;
            trace_reg_q   <= trace_reg_d;
            trace_data_q  <= trace_data_d;
            commit_cnt_q  <= commit_cnt_d;
        end
    end

    // Bypass lets decode see a value being written back in the same cycle.
    always_comb begin
        RD1 = regs_q[A1];
        if (A1 == '0) begin
            RD1 = '0;
        end else if (commit && (A1 == A3)) begin
            RD1 = WD;
        end
    end

    always_comb begin
        RD2 = regs_q[A2];
        if (A2 == '0) begin
            RD2 = '0;
        end else if (commit && (A2 == A3)) begin
            RD2 = WD;
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_pc    = trace_pc_q;
    assign trace_reg   = trace_reg_q;
    assign trace_data  = trace_data_q;
    assign commit_cnt  = commit_cnt_q;

endmodule

// File: tb/tb_grf_wb_sink.sv
// Randomized self-checking bench for grf_wb_sink against an array-based register
// file model; a second instance with a 4-bit counter exercises counter wrap.
module tb_grf_wb_sink;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  A3, A1, A2;
    logic [31:0] WD, PC4;

    logic [31:0] RD1, RD2, trace_pc, trace_data, commit_cnt;
    logic [4:0]  trace_reg;
    logic        trace_valid;

    logic [31:0] RD1b, RD2b, trace_pc_b, trace_data_b;
    logic [4:0]  trace_reg_b;
    logic        trace_valid_b;
    logic [3:0]  cnt4;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mdl [32];
    int unsigned mdlCnt;
    logic        expValid;
    logic [31:0] expPc, expData;
    logic [4:0]  expReg;

    always #5 clk = ~clk;

    grf_wb_sink dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .A3(A3), .WD(WD), .PC4(PC4),
        .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .trace_valid(trace_valid),
        .trace_pc(trace_pc), .trace_reg(trace_reg), .trace_data(trace_data),
        .commit_cnt(commit_cnt)
    );

    grf_wb_sink #(.CNT_W(4)) dutSmall (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .A3(A3), .WD(WD), .PC4(PC4),
        .A1(A1), .A2(A2), .RD1(RD1b), .RD2(RD2b), .trace_valid(trace_valid_b),
        .trace_pc(trace_pc_b), .trace_reg(trace_reg_b), .trace_data(trace_data_b),
        .commit_cnt(cnt4)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] mdlRead(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (RegWrite && A3 != 5'd0 && idx == A3) return WD;
        return mdl[idx];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        mdlCnt   = 0;
        expValid = 1'b0;
        expPc    = 32'd0;
        expReg   = 5'd0;
        expData  = 32'd0;
    endtask

    // One clock cycle: drive at the falling edge, check reads before the rising
    // edge, then check trace and counters just after it.
    task automatic applyStimulus(input logic rw, input logic [4:0] a3, input logic [31:0] wd,
                                 input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2);
        logic commit;
        @(negedge clk);
        RegWrite = rw; A3 = a3; WD = wd; PC4 = pc; A1 = a1; A2 = a2;
        #1;
        checkOutput("rd1", {32'd0, RD1}, {32'd0, mdlRead(a1)});
        checkOutput("rd2", {32'd0, RD2}, {32'd0, mdlRead(a2)});
        checkOutput("rd1_small", {32'd0, RD1b}, {32'd0, mdlRead(a1)});
        commit = rw && (a3 != 5'd0);
        @(posedge clk);
        expValid = commit;
        if (commit) begin
            mdl[a3] = wd;
            mdlCnt++;
            expPc   = pc;
            expReg  = a3;
            expData = wd;
        end
        #1;
        checkOutput("trace_valid", {63'd0, trace_valid}, {63'd0, expValid});
        checkOutput("trace_pc", {32'd0, trace_pc}, {32'd0, expPc});
        checkOutput("trace_reg", {59'd0, trace_reg}, {59'd0, expReg});
        checkOutput("trace_data", {32'd0, trace_data}, {32'd0, expData});
        checkOutput("commit_cnt", {32'd0, commit_cnt}, {32'd0, mdlCnt});
        checkOutput("commit_cnt4", {60'd0, cnt4}, {60'd0, 4'(mdlCnt % 16)});
    endtask

    initial begin
        logic [4:0] ra3, ra1, ra2;
        logic       rrw;
        $display("[TB] starting grf_wb_sink bench");
        reset = 1'b0; RegWrite = 1'b0; A3 = 5'd0; WD = 32'd0; PC4 = 32'd0; A1 = 5'd0; A2 = 5'd0;
        modelReset();
        repeat (3) @(posedge clk);

        // Every index reads zero after reset.
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i); A2 = 5'(31 - i);
            #1;
            checkOutput("reset_rd1", {32'd0, RD1}, 64'd0);
            checkOutput("reset_rd2", {32'd0, RD2}, 64'd0);
        end
        checkOutput("reset_valid", {63'd0, trace_valid}, 64'd0);
        checkOutput("reset_cnt", {32'd0, commit_cnt}, 64'd0);

        // Same-cycle bypass then trace one cycle later.
        applyStimulus(1'b1, 5'd8, 32'h12345678, 32'h00003000, 5'd8, 5'd0);
        checkOutput("bypass_cnt", {32'd0, commit_cnt}, 64'd1);
        checkOutput("bypass_trace_data", {32'd0, trace_data}, 64'h12345678);

        // Write to register 0 is discarded.
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 32'h00003004, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 32'h00003008, 5'd0, 5'd8);

        // Back-to-back writes to $5.
        applyStimulus(1'b1, 5'd5, 32'h1, 32'h0000300C, 5'd5, 5'd5);
        applyStimulus(1'b1, 5'd5, 32'h2, 32'h00003010, 5'd5, 5'd5);
        applyStimulus(1'b1, 5'd5, 32'h3, 32'h00003014, 5'd5, 5'd5);
        applyStimulus(1'b0, 5'd0, 32'd0, 32'h00003018, 5'd5, 5'd8);
        checkOutput("b2b_cnt", {32'd0, commit_cnt}, 64'd4);

        // Asynchronous reset mid-cycle clears storage immediately.
        applyStimulus(1'b1, 5'd31, 32'hDEADBEEF, 32'h0000301C, 5'd31, 5'd31);
        @(negedge clk);
        RegWrite = 1'b0; A1 = 5'd31; A2 = 5'd31;
        #1;
        checkOutput("pre_reset_rd31", {32'd0, RD1}, 64'hDEADBEEF);
        #1;
        reset = 1'b0;
        #1;
        modelReset();
        checkOutput("async_rd31", {32'd0, RD1}, 64'd0);
        checkOutput("async_valid", {63'd0, trace_valid}, 64'd0);
        checkOutput("async_cnt", {32'd0, commit_cnt}, 64'd0);
        checkOutput("async_trace_data", {32'd0, trace_data}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Seventeen commits wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 5'(1 + (i % 31)), $urandom, 32'h4000 + 32'(4 * i), 5'(1 + (i % 31)), 5'd0);
        end
        checkOutput("cnt4_wrap", {60'd0, cnt4}, 64'd1);
        checkOutput("cnt32_17", {32'd0, commit_cnt}, 64'd17);

        // Randomized traffic with deliberate index collisions.
        for (int i = 0; i < 400; i++) begin
            rrw = ($urandom_range(0, 3) != 0);
            ra3 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            ra1 = ($urandom_range(0, 2) == 0) ? ra3 : 5'($urandom);
            ra2 = ($urandom_range(0, 2) == 0) ? ra3 : 5'($urandom);
            applyStimulus(rrw, ra3, $urandom, $urandom, ra1, ra2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/grf_wb_sink.md
Name: grf_wb_sink

Overview:
- General register file that terminates the write-back interface: accepts RegWrite, write address and WD from the write-back stage.
- Serves two read ports to decode, with same-cycle write-to-read bypass.
- Emits a registered commit trace (PC, register, data) for bench comparison against a MARS-style golden log.
- Sits between the write-back stage (write side) and the decode stage / hazard logic (read side).

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width (2**ADDR_W registers)
- CNT_W, 32, width of the committed-write counter

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- RegWrite  input  1  write enable from the write-back stage
- A3  input  ADDR_W  write register index
- WD  input  DATA_W  write data from the write-back stage
- PC4  input  32  PC of the instruction in write-back, trace only
- A1  input  ADDR_W  read port 1 index
- A2  input  ADDR_W  read port 2 index
- RD1  output  DATA_W  read port 1 data, combinational
- RD2  output  DATA_W  read port 2 data, combinational
- trace_valid  output  1  one-cycle pulse: a write committed last cycle
- trace_pc  output  32  PC of the committed write
- trace_reg  output  ADDR_W  register index of the committed write
- trace_data  output  DATA_W  data of the committed write
- commit_cnt  output  CNT_W  number of committed writes since reset

Behaviour:
- Storage: 2**ADDR_W registers of DATA_W bits. Register 0 is hardwired to zero.
- Reset (reset=0, asynchronous):
  - all registers clear to 0
  - trace_valid=0; trace_pc, trace_reg, trace_data = 0
  - commit_cnt=0
  - reset takes effect immediately and overrides any write in progress; a write on the release edge is honoured only if reset is already 1 at that edge.
- Commit condition: commit = RegWrite && (A3 != 0).
  - A write to register 0 is discarded: no storage change, no trace, no count.
- Write: on a rising edge with commit=1, reg[A3] <= WD.
- Read, per port (combinational, same for both ports independently):
  - index 0 -> 0
  - else if commit && index==A3 -> WD (bypass; decode sees the value written this cycle)
  - else -> reg[index]
  - A1==A2==A3 with commit=1: both ports return WD.
- Trace (1-cycle latency):
  - on each edge, trace_valid <= commit
  - when commit=1: trace_pc <= PC4, trace_reg <= A3, trace_data <= WD
  - when commit=0: trace_pc, trace_reg and trace_data hold their previous values; only trace_valid drops.
  - Back-to-back commits produce back-to-back pulses, with no gap and no merging.
- Counter:
  - commit_cnt increments by 1 on each committed edge
  - wraps modulo 2**CNT_W, with no saturation
  - reads its new value the cycle after the write, aligned with trace_valid.
- X or undefined RegWrite is not tolerated: the bench must drive known values after reset release.
- No read-side state exists: RD1/RD2 depend only on the current inputs and the storage contents.

Test Plan:
- Reset then read all 32 indices on A1/A2 -> RD1=RD2=0 everywhere; trace_valid=0; commit_cnt=0.
- RegWrite=1, A3=8, WD=0x12345678, PC4=0x00003000, A1=8, all in the same cycle -> RD1=0x12345678 in that cycle (bypass). Next cycle: trace_valid=1, trace_reg=8, trace_data=0x12345678, trace_pc=0x00003000, commit_cnt=1.
- RegWrite=1, A3=0, WD=0xFFFFFFFF -> RD(0)=0 before and after the edge; trace_valid stays 0; commit_cnt unchanged.
- Writes to $5 on three consecutive cycles (0x1, 0x2, 0x3) with A1=A2=5 -> RDs show 0x1, 0x2, 0x3 in those cycles; trace_valid high for 3 consecutive cycles; final reg[5]=0x3; commit_cnt=+3.
- Drop reset to 0 asynchronously mid-cycle after writing $31=0xDEADBEEF -> RD(31)=0 immediately, before the next edge; trace_valid=0; commit_cnt=0.
- CNT_W=4: perform 17 committed writes -> commit_cnt wraps 15 -> 0 and ends at 1.
